bypass_bin_encoder: RTL and testbench
=====================================

Name: bypass_bin_encoder

Overview:
CABAC equiprobable (bypass) bin encoder for the VVC arithmetic coding path; the encoder-side counterpart of the bypass bin decode stage. It accepts one bypass bin per handshake and updates the low register (low = 2*low + bin*range). It renormalises bytes out through an outstanding-byte buffer with carry propagation. The bitstream writer sits downstream; a terminate/flush stage consumes the exported low/bits-left state.

Parameters:
CNT_W, 16, width of the outstanding 0xFF byte counter (num_buffered)

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
init  input  1  slice start: reinitialise coder state (synchronous pulse)
bin_valid  input  1  bin_in/m_range valid
bin_ready  output  1  encoder accepts a bin this cycle
bin_in  input  1  bypass bin value
m_range  input  9  current range (256..510), sampled with the bin
byte_valid  output  1  byte_out valid
byte_ready  input  1  downstream accepts byte
byte_out  output  8  emitted bitstream byte
low_out  output  32  current low register
bits_left_out  output  5  current bits-left counter
num_buffered_out  output  CNT_W  outstanding byte count
buffered_byte_out  output  8  held byte awaiting carry resolution
err  output  1  sticky: num_buffered overflow

Behaviour:
- Clocking and reset: one clock. rst_n low (async) and init (sync) both set the following:
  - low=0, bits_left=23, num_buffered=0, buffered_byte=0xFF, err=0.
  - State=RUN, byte_valid=0, byte_out=0x00.
- init precedence: init overrides any bin or byte handshake in the same cycle. init mid-drain aborts the drain; pending bytes are discarded and byte_valid drops next cycle.
- States: RUN, WRITE, EMIT_FIRST, EMIT_REST.
- RUN:
  - bin_ready=1.
  - On accept: low <= (low<<1) + (bin_in ? m_range : 0), 32-bit wrap; bits_left <= bits_left-1.
  - If the new bits_left < 12, go to WRITE; else stay in RUN. One bin per cycle at full throughput.
- WRITE (bin_ready=0), one cycle:
  - lead = low >> (24 - bits_left), 9 bits; bit 8 = carry.
  - bits_left += 8; low &= 0xFFFFFFFF >> (new bits_left).
  - lead==0x0FF: num_buffered++ (err set if at max; counter saturates), go to RUN.
  - Else if num_buffered==0: num_buffered=1, buffered_byte=lead[7:0], go to RUN.
  - Else: latch first=buffered_byte+carry (8-bit) and fill=(0xFF+carry)&0xFF; set buffered_byte=lead[7:0]; go to EMIT_FIRST.
- EMIT_FIRST:
  - byte_valid=1, byte_out=first, held stable until byte_ready.
  - On handshake: if num_buffered>1, go to EMIT_REST; else num_buffered=1 and go to RUN.
- EMIT_REST:
  - byte_valid=1, byte_out=fill.
  - Each handshake decrements num_buffered. When the handshake occurs with num_buffered==2, set num_buffered=1 and go to RUN.
- byte_valid=0 in RUN and WRITE.
- bin_ready=0 in every state except RUN.
- Backpressure: byte_ready low holds the state and byte_out stable indefinitely.
- Latency: accepted bin reflected in low_out next cycle. A byte-producing renorm shows byte_valid 2 cycles after the triggering bin handshake.

Test Plan:
1. Reset then 20 bins of 0, range 256 → first WRITE buffers 0x00 (num_buffered=1, no output); second WRITE emits exactly one byte 0x00; low_out=0, bits_left_out=19.
2. init then 36 bins of 1, range 256 → no bytes emitted. Then check:
   - After bin 12: buffered_byte=0x7F, low_out=7936.
   - Final: num_buffered=4, bits_left_out=19, low_out=7936.
3. Continue from 2 with 8 bins of 1, range 510 → carry (lead=0x107).
   - Bytes emitted in order: 0x80, 0x00, 0x00, 0x00.
   - Final: buffered_byte=0x07, num_buffered=1.
4. Repeat 3 with byte_ready low for 5 cycles at each byte:
   - byte_out stable while stalled, bin_ready=0 throughout the drain.
   - Same 4 bytes, none duplicated or dropped.
5. Pulse init during EMIT_REST of scenario 3 → next cycle byte_valid=0, low_out=0, bits_left_out=23, num_buffered_out=0, buffered_byte_out=0xFF, bin_ready=1.
6. Assert rst_n low asynchronously mid-RUN (no clock edge) → all outputs reach reset values immediately; err=0.

Source files
------------

// File: rtl/bypass_bin_encoder.sv
// bypass_bin_encoder: CABAC bypass bin encoder with outstanding-byte carry buffer
module bypass_bin_encoder #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             init,
   input  logic             bin_valid,
   output logic             bin_ready,
   input  logic             bin_in,
   input  logic [8:0]       m_range,
   output logic             byte_valid,
   input  logic             byte_ready,
   output logic [7:0]       byte_out,
   output logic [31:0]      low_out,
   output logic [4:0]       bits_left_out,
   output logic [CNT_W-1:0] num_buffered_out,
   output logic [7:0]       buffered_byte_out,
   output logic             err
);
   typedef enum logic [1:0] {RUN, WRITE, EMIT_FIRST, EMIT_REST} state_t;
   state_t state;
   logic [31:0] low, low_acc;
   logic [4:0] bits_left, bl_dec, bl_inc;
   logic [5:0] shift;
   logic [8:0] lead;
   logic [CNT_W-1:0] num_buffered;
   logic [7:0] buffered_byte, fill;
   always_comb begin
      low_acc = {low[30:0], 1'b0} + (bin_in ? {23'd0, m_range} : 32'd0);
      bl_dec = bits_left - 5'd1;
      bl_inc = bits_left + 5'd8;
      shift = 6'd24 - {1'b0, bits_left};
      lead = 9'(low >> shift);
   end
   assign bin_ready = state == RUN;
   assign low_out = low;
   assign bits_left_out = bits_left;
   assign num_buffered_out = num_buffered;
   assign buffered_byte_out = buffered_byte;
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RUN;
         low <= '0;
         bits_left <= 5'd23;
         num_buffered <= '0;
         buffered_byte <= 8'hFF;
         fill <= 8'h00;
         err <= 1'b0;
         byte_valid <= 1'b0;
         byte_out <= 8'h00;
      end else if (init) begin
         state <= RUN;
         low <= '0;
         bits_left <= 5'd23;
         num_buffered <= '0;
         buffered_byte <= 8'hFF;
         fill <= 8'h00;
         err <= 1'b0;
         byte_valid <= 1'b0;
         byte_out <= 8'h00;
      end else begin
         case (state)
            RUN: if (bin_valid) begin
               low <= low_acc;
               bits_left <= bl_dec;
               if (bl_dec < 5'd12) state <= WRITE;
            end
            WRITE: begin
               bits_left <= bl_inc;
               low <= low & (32'hFFFF_FFFF >> bl_inc);
               if (lead == 9'h0FF) begin
                  // a 0xFF byte may still absorb a later carry, so it is only counted
                  num_buffered <= num_buffered + CNT_W'(!(&num_buffered));
                  err <= err | (&num_buffered);
                  state <= RUN;
               end else if (num_buffered == '0) begin
                  num_buffered <= CNT_W'(1);
                  buffered_byte <= lead[7:0];
                  state <= RUN;
               end else begin
                  byte_out <= buffered_byte + {7'd0, lead[8]};
                  fill <= {8{~lead[8]}};
                  buffered_byte <= lead[7:0];
                  byte_valid <= 1'b1;
                  state <= EMIT_FIRST;
               end
            end
            EMIT_FIRST: if (byte_ready) begin
               if (num_buffered > CNT_W'(1)) begin
                  byte_out <= fill;
                  state <= EMIT_REST;
               end else begin
                  num_buffered <= CNT_W'(1);
                  byte_valid <= 1'b0;
                  state <= RUN;
               end
            end
            EMIT_REST: if (byte_ready) begin
               num_buffered <= num_buffered - CNT_W'(1);
               if (num_buffered == CNT_W'(2)) begin
                  byte_valid <= 1'b0;
                  state <= RUN;
               end
            end
            default: state <= RUN;
         endcase
      end
   end
endmodule

// File: tb/tb_bypass_bin_encoder.sv
// tb_bypass_bin_encoder: directed bench with a byte scoreboard for bypass_bin_encoder
module tb_bypass_bin_encoder;
   localparam int CNT_W = 16;
   logic clk = 0, rst_n = 0, init = 0, bin_valid = 0, bin_in = 0, byte_ready = 1;
   logic [8:0] m_range = 9'd256;
   logic bin_ready, byte_valid, err;
   logic [7:0] byte_out, buffered_byte_out;
   logic [31:0] low_out;
   logic [4:0] bits_left_out;
   logic [CNT_W-1:0] num_buffered_out;
   int checks = 0, errors = 0, stall_len = 0;
   logic [7:0] exp_q[$];

   always #5 clk = ~clk;

   bypass_bin_encoder #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .init(init), .bin_valid(bin_valid), .bin_ready(bin_ready),
      .bin_in(bin_in), .m_range(m_range), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .byte_out(byte_out), .low_out(low_out), .bits_left_out(bits_left_out),
      .num_buffered_out(num_buffered_out), .buffered_byte_out(buffered_byte_out), .err(err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic send_bin(input logic b, input logic [8:0] r);
      int n = 0;
      @(negedge clk);
      bin_valid = 1; bin_in = b; m_range = r;
      while (!bin_ready && n < 100) begin
         @(negedge clk);
         n++;
      end
      if (!bin_ready) chk("bin accept timeout", bin_ready, 1);
      @(posedge clk);
      #1 bin_valid = 0;
   endtask

   task automatic send_n(input int n, input logic b, input logic [8:0] r);
      repeat (n) send_bin(b, r);
   endtask

   task automatic wait_idle();
      int n = 0;
      @(negedge clk);
      while (!(bin_ready && !byte_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("idle timeout", bin_ready && !byte_valid, 1);
   endtask

   task automatic do_init();
      @(negedge clk);
      init = 1;
      @(posedge clk);
      #1 init = 0;
   endtask

   task automatic chk_cleared(input string tag);
      chk({tag, " low"}, low_out, 0);
      chk({tag, " bits_left"}, bits_left_out, 23);
      chk({tag, " num_buffered"}, num_buffered_out, 0);
      chk({tag, " buffered_byte"}, buffered_byte_out, 8'hFF);
      chk({tag, " byte_valid"}, byte_valid, 0);
      chk({tag, " bin_ready"}, bin_ready, 1);
      chk({tag, " err"}, err, 0);
   endtask

   task automatic chk_carry_end(input string tag);
      chk({tag, " buffered_byte"}, buffered_byte_out, 8'h07);
      chk({tag, " num_buffered"}, num_buffered_out, 1);
      chk({tag, " low"}, low_out, 7170);
      chk({tag, " bits_left"}, bits_left_out, 19);
      chk({tag, " bytes left"}, exp_q.size(), 0);
   endtask

   // byte_ready: held low for stall_len cycles at the start of every offered byte
   initial begin
      int cnt = 0;
      logic hs;
      forever begin
         @(negedge clk);
         hs = byte_valid && byte_ready;
         @(posedge clk);
         #1;
         if (hs || !byte_valid) cnt = 0;
         if (byte_valid && cnt < stall_len) begin
            byte_ready = 0;
            cnt++;
         end else byte_ready = 1;
      end
   end

   initial begin
      logic prev_stall = 0;
      logic [7:0] prev_byte = 0;
      forever begin
         @(negedge clk);
         if (byte_valid) begin
            chk("bin_ready during drain", bin_ready, 0);
            if (prev_stall) chk("byte_out stable", byte_out, prev_byte);
            if (byte_ready) begin
               if (exp_q.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected byte: got %0h expected none", byte_out);
               end else chk("byte_out", byte_out, exp_q.pop_front());
            end
         end
         prev_stall = byte_valid && !byte_ready;
         prev_byte = byte_out;
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int n;
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1;
      @(negedge clk);
      chk_cleared("reset");
      chk("reset byte_out", byte_out, 0);
      // zeros: first renorm only buffers, second emits one 0x00
      send_n(12, 0, 256);
      wait_idle();
      chk("s1 num_buffered", num_buffered_out, 1);
      chk("s1 buffered_byte", buffered_byte_out, 0);
      exp_q.push_back(8'h00);
      send_n(8, 0, 256);
      @(negedge clk);
      chk("s1 valid in WRITE", byte_valid, 0);
      chk("s1 bin_ready in WRITE", bin_ready, 0);
      @(negedge clk);
      chk("s1 valid latency", byte_valid, 1);
      wait_idle();
      chk("s1 low", low_out, 0);
      chk("s1 bits_left", bits_left_out, 19);
      chk("s1 num_buffered end", num_buffered_out, 1);
      chk("s1 bytes left", exp_q.size(), 0);
      // ones at range 256: 0x7F buffered then three 0xFF outstanding
      do_init();
      send_bin(1, 256);
      @(negedge clk);
      chk("s2 low after 1 bin", low_out, 256);
      send_n(11, 1, 256);
      wait_idle();
      chk("s2 buffered_byte", buffered_byte_out, 8'h7F);
      chk("s2 low after 12", low_out, 7936);
      send_n(24, 1, 256);
      wait_idle();
      chk("s2 num_buffered", num_buffered_out, 4);
      chk("s2 bits_left", bits_left_out, 19);
      chk("s2 low", low_out, 7936);
      // carry ripples through the outstanding bytes
      exp_q.push_back(8'h80); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      send_n(8, 1, 510);
      wait_idle();
      chk_carry_end("s3");
      // same carry drain under backpressure
      stall_len = 5;
      do_init();
      send_n(36, 1, 256);
      exp_q.push_back(8'h80); exp_q.push_back(8'h00); exp_q.push_back(8'h00); exp_q.push_back(8'h00);
      send_n(8, 1, 510);
      wait_idle();
      chk_carry_end("s4");
      // init in the middle of the fill bytes
      do_init();
      send_n(36, 1, 256);
      exp_q.push_back(8'h80);
      send_n(8, 1, 510);
      n = 0;
      @(negedge clk);
      while (!(byte_valid && byte_out == 8'h00 && !byte_ready) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("s5 reached fill byte", byte_valid && byte_out == 8'h00 && !byte_ready, 1);
      chk("s5 num_buffered in drain", num_buffered_out, 4);
      init = 1;
      @(posedge clk);
      #1 init = 0;
      stall_len = 0;
      @(negedge clk);
      chk_cleared("s5");
      chk("s5 bytes left", exp_q.size(), 0);
      // asynchronous reset away from any clock edge
      send_n(5, 1, 256);
      @(negedge clk);
      chk("s6 low before reset", low_out, 7936);
      chk("s6 bits_left before reset", bits_left_out, 18);
      #2 rst_n = 0;
      #1;
      chk_cleared("s6");
      chk("s6 byte_out", byte_out, 0);
      @(negedge clk) rst_n = 1;
      @(negedge clk);
      chk("s6 low after release", low_out, 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
